fir_tap_ctrl: RTL and testbench

Sequencing and coefficient-management controller for a chain of transposed-FIR multiply/add/shift tiles, each holding 3 taps. It derives the 300 kHz sample strobe from the 12 MHz clock and drives the per-tile enables. It also holds a double-buffered coefficient bank: the host writes a shadow bank, and the new set goes live atomically on a sample boundary. It sits between the host register interface and the FIR tile chain.

---
 rtl/fir_tap_ctrl_if.sv | 43 ++++
 rtl/fir_tap_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fir_tap_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_ctrl_if.sv
// Host-side coefficient port of fir_tap_ctrl: shadow writes, commit handshake, status.
// The readback pair exists only when FIR_CTRL_READBACK_EN is defined.
interface fir_tap_ctrl_if;
  logic        iCoeffWrEn;
  logic [3:0]  iCoeffAddr;
  logic [15:0] iCoeffData;
  logic        iCoeffCommit;
  logic        oCoeffWrRdy;
  logic        oCommitDone;
  logic        oAddrErr;
`ifdef FIR_CTRL_READBACK_EN
  logic        iCoeffRdEn;
  logic [15:0] oCoeffRdData;
`endif

  modport master (
    output iCoeffWrEn,
    output iCoeffAddr,
    output iCoeffData,
    output iCoeffCommit,
`ifdef FIR_CTRL_READBACK_EN
    output iCoeffRdEn,
    input  oCoeffRdData,
`endif
    input  oCoeffWrRdy,
    input  oCommitDone,
    input  oAddrErr
  );

  modport slave (
    input  iCoeffWrEn,
    input  iCoeffAddr,
    input  iCoeffData,
    input  iCoeffCommit,
`ifdef FIR_CTRL_READBACK_EN
    input  iCoeffRdEn,
    output oCoeffRdData,
`endif
    output oCoeffWrRdy,
    output oCommitDone,
    output oAddrErr
  );
endinterface

// File: rtl/fir_tap_ctrl.sv
// Sample-strobe sequencer and double-buffered coefficient bank for a chain of 3-tap FIR tiles.
// Define FIR_CTRL_READBACK_EN to add a shadow-bank readback port.
module fir_tap_ctrl #(
  parameter int CLK_DIV  = 40,
  parameter int NUM_TILE = 4
) (
  input  logic                      iClk_12M,
  input  logic                      iRsn,
  input  logic                      iEnFir,
  fir_tap_ctrl_if.slave             coeff_if,
  output logic                      oEnSample_300k,
  output logic [NUM_TILE-1:0]       oEnMul,
  output logic                      oEnAdd,
  output logic                      oEnAcc,
  output logic [16*3*NUM_TILE-1:0]  oCoeffBus
);

  localparam int               NUM_TAP   = 3 * NUM_TILE;
  localparam int               CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [4:0]       NUM_TAP_W = 5'(NUM_TAP);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    SWAP_PEND = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             from_run;
  logic             from_run_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;
  logic             strobe_q;
  logic             strobe_nxt;
  logic             running;
  logic             running_nxt;
  logic             swap;
  logic             commit_done_q;
  logic             addr_err_q;
  logic             wr_rdy;
  logic             wr_acc;
  logic             cmt_acc;
  logic             addr_ok;
  logic [15:0]      shadow [NUM_TAP];
  logic [15:0]      active [NUM_TAP];

  assign wr_rdy  = (state != SWAP_PEND);
  assign wr_acc  = coeff_if.iCoeffWrEn & wr_rdy;
  assign cmt_acc = coeff_if.iCoeffCommit & wr_rdy;
  assign addr_ok = ({1'b0, coeff_if.iCoeffAddr} < NUM_TAP_W);
  assign running = (state == RUN) || ((state == SWAP_PEND) && from_run);

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state    <= IDLE;
      from_run <= 1'b0;
      div_cnt  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      from_run <= from_run_nxt;
      div_cnt  <= div_cnt_nxt;
      strobe_q <= strobe_nxt;
    end
  end

  // A pending swap taken from RUN waits for the strobe cycle so the tiles see the
  // old set on that strobe; otherwise (idle, or iEnFir dropped) it lands on the next edge.
  always_comb begin
    state_nxt    = state;
    from_run_nxt = from_run;
    swap         = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (cmt_acc) begin
          state_nxt    = SWAP_PEND;
          from_run_nxt = (state == RUN) && iEnFir;
        end else begin
          state_nxt    = iEnFir ? RUN : IDLE;
          from_run_nxt = 1'b0;
        end
      end
      SWAP_PEND: begin
        if (!from_run || !iEnFir || strobe_q) begin
          swap         = 1'b1;
          state_nxt    = iEnFir ? RUN : IDLE;
          from_run_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        from_run_nxt = 1'b0;
      end
    endcase

    running_nxt = (state_nxt == RUN) || ((state_nxt == SWAP_PEND) && from_run_nxt);

    // The divider restarts from zero whenever it is (re)started and stops cleared.
    div_cnt_nxt = '0;
    if (running_nxt && running)
      div_cnt_nxt = (div_cnt == CNT_MAX) ? '0 : div_cnt + 1'b1;

    strobe_nxt = running && running_nxt && (div_cnt == CNT_MAX);
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < NUM_TAP; k++)
        shadow[k] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < NUM_TAP; k++)
        if (coeff_if.iCoeffAddr == 4'(k))
          shadow[k] <= coeff_if.iCoeffData;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < NUM_TAP; k++)
        active[k] <= '0;
    end else if (swap) begin
      for (int k = 0; k < NUM_TAP; k++)
        active[k] <= shadow[k];
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      commit_done_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      commit_done_q <= swap;
      if (wr_acc && !addr_ok)
        addr_err_q <= 1'b1;
    end
  end

  assign coeff_if.oCoeffWrRdy = wr_rdy;
  assign coeff_if.oCommitDone = commit_done_q;
  assign coeff_if.oAddrErr    = addr_err_q;
  assign oEnSample_300k       = strobe_q;
  assign oEnAdd               = running;
  assign oEnAcc               = running;

  for (genvar k = 0; k < NUM_TAP; k++) begin : g_bus
    assign oCoeffBus[16*k +: 16] = active[k];
  end

  // Tiles whose three active taps are all zero contribute nothing, so their multipliers idle.
  for (genvar t = 0; t < NUM_TILE; t++) begin : g_mul
    assign oEnMul[t] = running && ((active[3*t] != '0) || (active[3*t+1] != '0) ||
                                   (active[3*t+2] != '0));
  end

`ifdef FIR_CTRL_READBACK_EN
  logic [15:0] rd_mux;
  logic [15:0] rd_data_q;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_TAP; k++)
      if (coeff_if.iCoeffAddr == 4'(k))
        rd_mux = shadow[k];
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn)
      rd_data_q <= '0;
    else if (coeff_if.iCoeffRdEn)
      rd_data_q <= rd_mux;
  end

  assign coeff_if.oCoeffRdData = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Scoreboard bench for fir_tap_ctrl: strobe timing, commit paths, address errors and reset.
module tb_fir_tap_ctrl;
  localparam int CLK_DIV  = 40;
  localparam int NUM_TILE = 4;
  localparam int NUM_TAP  = 3 * NUM_TILE;
  localparam int BUS_W    = 16 * NUM_TAP;

  typedef struct {
    int               due;
    logic [BUS_W-1:0] bus;
  } exp_t;

  logic                iClk_12M;
  logic                iRsn;
  logic                iEnFir;
  logic                oEnSample_300k;
  logic [NUM_TILE-1:0] oEnMul;
  logic                oEnAdd;
  logic                oEnAcc;
  logic [BUS_W-1:0]    oCoeffBus;

  int               tests = 0;
  int               fails = 0;
  int               cyc   = 0;
  exp_t             sb[$];
  logic [BUS_W-1:0] m_shadow;
  logic [BUS_W-1:0] m_active;

  fir_tap_ctrl_if coeff_if();

  fir_tap_ctrl #(.CLK_DIV(CLK_DIV), .NUM_TILE(NUM_TILE)) dut (
    .iClk_12M       (iClk_12M),
    .iRsn           (iRsn),
    .iEnFir         (iEnFir),
    .coeff_if       (coeff_if),
    .oEnSample_300k (oEnSample_300k),
    .oEnMul         (oEnMul),
    .oEnAdd         (oEnAdd),
    .oEnAcc         (oEnAcc),
    .oCoeffBus      (oCoeffBus)
  );

  initial iClk_12M = 1'b0;
  always #5 iClk_12M = ~iClk_12M;
  always @(posedge iClk_12M) cyc <= cyc + 1;

  function automatic logic [NUM_TILE-1:0] model_mul(input logic run, input logic [BUS_W-1:0] bank);
    logic [NUM_TILE-1:0] r;
    r = '0;
    for (int t = 0; t < NUM_TILE; t++)
      r[t] = run && (bank[48*t +: 48] != '0);
    return r;
  endfunction

  task automatic clear_inputs();
    coeff_if.iCoeffWrEn   = 1'b0;
    coeff_if.iCoeffAddr   = 4'd0;
    coeff_if.iCoeffData   = 16'h0000;
    coeff_if.iCoeffCommit = 1'b0;
`ifdef FIR_CTRL_READBACK_EN
    coeff_if.iCoeffRdEn   = 1'b0;
`endif
  endtask

  task automatic drive_write(input logic [3:0] addr, input logic [15:0] data, input logic commit);
    coeff_if.iCoeffWrEn   = 1'b1;
    coeff_if.iCoeffAddr   = addr;
    coeff_if.iCoeffData   = data;
    coeff_if.iCoeffCommit = commit;
  endtask

  task automatic test_reset();
    iRsn = 1'b0;
    iEnFir = 1'b0;
    clear_inputs();
    m_shadow = '0;
    m_active = '0;
    repeat (2) @(negedge iClk_12M);
    tests++;
    if ({oEnSample_300k, oEnMul, oEnAdd, oEnAcc, coeff_if.oCoeffWrRdy, coeff_if.oCommitDone,
         coeff_if.oAddrErr} !== 10'b0_0000_00_1_0_0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected %b", {oEnSample_300k, oEnMul, oEnAdd, oEnAcc,
               coeff_if.oCoeffWrRdy, coeff_if.oCommitDone, coeff_if.oAddrErr}, 10'b0_0000_00_1_0_0);
    end
    tests++;
    if (oCoeffBus !== '0) begin
      fails++;
      $display("[TB] FAIL reset_bus: got %h expected 0", oCoeffBus);
    end
    iRsn = 1'b1;
    repeat (3) @(negedge iClk_12M);
    tests++;
    if ({oEnSample_300k, oEnAdd, coeff_if.oCoeffWrRdy} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL reset_idle: got %b expected 001", {oEnSample_300k, oEnAdd, coeff_if.oCoeffWrRdy});
    end
  endtask

  task automatic test_strobe();
    int due_q[$];
    int start;
    int due;
    iEnFir = 1'b1;
    start = cyc;
    for (int k = 1; k <= 3; k++) due_q.push_back(start + 1 + CLK_DIV * k);
    repeat (3 * CLK_DIV + 5) begin
      @(negedge iClk_12M);
      if (oEnSample_300k) begin
        tests++;
        if (due_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL strobe_extra: strobe at cycle %0d, none expected", cyc);
        end else begin
          due = due_q.pop_front();
          if (cyc != due) begin
            fails++;
            $display("[TB] FAIL strobe_time: strobe at cycle %0d expected %0d", cyc, due);
          end
        end
      end
    end
    tests++;
    if (due_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL strobe_missing: %0d strobes not seen, expected 0", due_q.size());
    end
    tests++;
    if ({oEnAdd, oEnAcc, oEnMul} !== 6'b11_0000) begin
      fails++;
      $display("[TB] FAIL strobe_enables: got %b expected 110000", {oEnAdd, oEnAcc, oEnMul});
    end
  endtask

  task automatic test_commit_run();
    int   c0;
    logic seen;
    logic got;
    logic rdy_early;
    exp_t e;
    seen = 1'b0;
    for (int n = 0; n < 2 * CLK_DIV && !seen; n++) begin
      @(negedge iClk_12M);
      if (oEnSample_300k) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL commit_run_sync: no strobe got 0 expected 1");
    end
    c0 = cyc;
    drive_write(4'd4, 16'h0123, 1'b1);
    m_shadow[16*4 +: 16] = 16'h0123;
    sb.push_back('{due: c0 + 1 + CLK_DIV, bus: m_shadow});
    m_active = m_shadow;
    @(negedge iClk_12M);
    tests++;
    if (coeff_if.oCoeffWrRdy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL commit_run_rdy: got %b expected 0", coeff_if.oCoeffWrRdy);
    end
    drive_write(4'd5, 16'h5555, 1'b1);
    @(negedge iClk_12M);
    clear_inputs();
    got = 1'b0;
    rdy_early = 1'b0;
    for (int n = 0; n < CLK_DIV + 8; n++) begin
      if (n > 0) @(negedge iClk_12M);
      if (coeff_if.oCommitDone) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL commit_run_spurious: done at cycle %0d, none expected", cyc);
        end else begin
          e = sb.pop_front();
          got = 1'b1;
          if (cyc != e.due || oCoeffBus !== e.bus) begin
            fails++;
            $display("[TB] FAIL commit_run_swap: cycle %0d bus %h expected cycle %0d bus %h", cyc, oCoeffBus, e.due, e.bus);
          end
        end
      end else if (!got && coeff_if.oCoeffWrRdy) begin
        rdy_early = 1'b1;
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL commit_run_timeout: done got 0 expected 1");
    end
    tests++;
    if (rdy_early !== 1'b0) begin
      fails++;
      $display("[TB] FAIL commit_run_rdy_hold: early ready got 1 expected 0");
    end
    tests++;
    if ({oEnMul, coeff_if.oCoeffWrRdy} !== 5'b0010_1) begin
      fails++;
      $display("[TB] FAIL commit_run_mul: got %b expected 00101", {oEnMul, coeff_if.oCoeffWrRdy});
    end
  endtask

  task automatic test_commit_idle();
    int               c0;
    logic             got;
    logic [BUS_W-1:0] old_bus;
    exp_t             e;
    iEnFir = 1'b0;
    repeat (3) @(negedge iClk_12M);
    tests++;
    if ({oEnAdd, oEnAcc, oEnMul, oEnSample_300k} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL idle_enables: got %b expected 0000000", {oEnAdd, oEnAcc, oEnMul, oEnSample_300k});
    end
    old_bus = m_active;
    c0 = cyc;
    drive_write(4'd0, 16'h7FFF, 1'b1);
    m_shadow[15:0] = 16'h7FFF;
    sb.push_back('{due: c0 + 2, bus: m_shadow});
    m_active = m_shadow;
    @(negedge iClk_12M);
    clear_inputs();
    tests++;
    if ({coeff_if.oCoeffWrRdy, coeff_if.oCommitDone} !== 2'b00 || oCoeffBus !== old_bus) begin
      fails++;
      $display("[TB] FAIL idle_pending: rdy/done %b bus %h expected 00 bus %h",
               {coeff_if.oCoeffWrRdy, coeff_if.oCommitDone}, oCoeffBus, old_bus);
    end
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge iClk_12M);
      if (coeff_if.oCommitDone) begin
        got = 1'b1;
        tests++;
        e = sb.pop_front();
        if (cyc != e.due || oCoeffBus !== e.bus) begin
          fails++;
          $display("[TB] FAIL idle_swap: cycle %0d bus %h expected cycle %0d bus %h", cyc, oCoeffBus, e.due, e.bus);
        end
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL idle_timeout: done got 0 expected 1");
    end
    @(negedge iClk_12M);
    tests++;
    if ({coeff_if.oCommitDone, coeff_if.oCoeffWrRdy} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL idle_pulse: done/rdy got %b expected 01", {coeff_if.oCommitDone, coeff_if.oCoeffWrRdy});
    end
  endtask

  task automatic test_addr_err();
    logic got;
    exp_t e;
    tests++;
    if (coeff_if.oAddrErr !== 1'b0) begin
      fails++;
      $display("[TB] FAIL addr_err_pre: got %b expected 0", coeff_if.oAddrErr);
    end
    drive_write(4'd13, 16'hBEEF, 1'b0);
    @(negedge iClk_12M);
    clear_inputs();
    tests++;
    if (coeff_if.oAddrErr !== 1'b1) begin
      fails++;
      $display("[TB] FAIL addr_err_set: got %b expected 1", coeff_if.oAddrErr);
    end
    drive_write(4'd3, 16'h0003, 1'b1);
    m_shadow[16*3 +: 16] = 16'h0003;
    sb.push_back('{due: cyc + 2, bus: m_shadow});
    m_active = m_shadow;
    @(negedge iClk_12M);
    clear_inputs();
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge iClk_12M);
      if (coeff_if.oCommitDone) begin
        got = 1'b1;
        tests++;
        e = sb.pop_front();
        if (cyc != e.due || oCoeffBus !== e.bus) begin
          fails++;
          $display("[TB] FAIL addr_err_bank: cycle %0d bus %h expected cycle %0d bus %h", cyc, oCoeffBus, e.due, e.bus);
        end
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL addr_err_timeout: done got 0 expected 1");
    end
    repeat (5) @(negedge iClk_12M);
    tests++;
    if (coeff_if.oAddrErr !== 1'b1) begin
      fails++;
      $display("[TB] FAIL addr_err_sticky: got %b expected 1", coeff_if.oAddrErr);
    end
  endtask

  task automatic test_drop_enfir();
    logic seen;
    logic got;
    logic strobe_after;
    exp_t e;
    iEnFir = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 2 * CLK_DIV && !seen; n++) begin
      @(negedge iClk_12M);
      if (oEnSample_300k) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL drop_sync: no strobe got 0 expected 1");
    end
    drive_write(4'd11, 16'h0042, 1'b1);
    m_shadow[16*11 +: 16] = 16'h0042;
    @(negedge iClk_12M);
    clear_inputs();
    repeat (4) @(negedge iClk_12M);
    tests++;
    if ({coeff_if.oCoeffWrRdy, oEnAdd, coeff_if.oCommitDone} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL drop_pending: rdy/add/done got %b expected 010",
               {coeff_if.oCoeffWrRdy, oEnAdd, coeff_if.oCommitDone});
    end
    iEnFir = 1'b0;
    sb.push_back('{due: cyc + 1, bus: m_shadow});
    m_active = m_shadow;
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge iClk_12M);
      if (coeff_if.oCommitDone) begin
        got = 1'b1;
        tests++;
        e = sb.pop_front();
        if (cyc != e.due || oCoeffBus !== e.bus || oEnAdd !== 1'b0) begin
          fails++;
          $display("[TB] FAIL drop_swap: cycle %0d bus %h add %b expected cycle %0d bus %h add 0",
                   cyc, oCoeffBus, oEnAdd, e.due, e.bus);
        end
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL drop_timeout: done got 0 expected 1");
    end
    strobe_after = 1'b0;
    repeat (2 * CLK_DIV) begin
      @(negedge iClk_12M);
      if (oEnSample_300k) strobe_after = 1'b1;
    end
    tests++;
    if (strobe_after !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drop_no_strobe: strobe seen got 1 expected 0");
    end
  endtask

  task automatic test_async_reset();
    logic got;
    exp_t e;
    iEnFir = 1'b1;
    repeat (10) @(negedge iClk_12M);
    tests++;
    if ({oEnAdd, oEnMul} !== {1'b1, model_mul(1'b1, m_active)}) begin
      fails++;
      $display("[TB] FAIL rst_running: got %b expected %b", {oEnAdd, oEnMul}, {1'b1, model_mul(1'b1, m_active)});
    end
    #2;
    iRsn = 1'b0;
    #1;
    tests++;
    if ({oEnSample_300k, oEnMul, oEnAdd, oEnAcc, coeff_if.oCoeffWrRdy, coeff_if.oCommitDone,
         coeff_if.oAddrErr} !== 10'b0_0000_00_1_0_0 || oCoeffBus !== '0) begin
      fails++;
      $display("[TB] FAIL rst_async: ctrl %b bus %h expected 0000000100 bus 0", {oEnSample_300k, oEnMul,
               oEnAdd, oEnAcc, coeff_if.oCoeffWrRdy, coeff_if.oCommitDone, coeff_if.oAddrErr}, oCoeffBus);
    end
    iEnFir = 1'b0;
    m_shadow = '0;
    m_active = '0;
    @(negedge iClk_12M);
    iRsn = 1'b1;
    @(negedge iClk_12M);
    coeff_if.iCoeffCommit = 1'b1;
    sb.push_back('{due: cyc + 2, bus: m_shadow});
    @(negedge iClk_12M);
    clear_inputs();
    got = 1'b0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge iClk_12M);
      if (coeff_if.oCommitDone) begin
        got = 1'b1;
        tests++;
        e = sb.pop_front();
        if (cyc != e.due || oCoeffBus !== e.bus) begin
          fails++;
          $display("[TB] FAIL rst_bank_lost: cycle %0d bus %h expected cycle %0d bus %h", cyc, oCoeffBus, e.due, e.bus);
        end
      end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("[TB] FAIL rst_timeout: done got 0 expected 1");
    end
  endtask

`ifdef FIR_CTRL_READBACK_EN
  task automatic test_readback();
    drive_write(4'd2, 16'hFFF0, 1'b0);
    @(negedge iClk_12M);
    clear_inputs();
    coeff_if.iCoeffRdEn = 1'b1;
    coeff_if.iCoeffAddr = 4'd2;
    @(negedge iClk_12M);
    coeff_if.iCoeffRdEn = 1'b0;
    tests++;
    if (coeff_if.oCoeffRdData !== 16'hFFF0) begin
      fails++;
      $display("[TB] FAIL readback_tap2: got %h expected fff0", coeff_if.oCoeffRdData);
    end
    coeff_if.iCoeffRdEn = 1'b1;
    coeff_if.iCoeffAddr = 4'd15;
    @(negedge iClk_12M);
    clear_inputs();
    tests++;
    if (coeff_if.oCoeffRdData !== 16'h0000 || coeff_if.oAddrErr !== 1'b0) begin
      fails++;
      $display("[TB] FAIL readback_oob: data %h err %b expected 0000 err 0", coeff_if.oCoeffRdData, coeff_if.oAddrErr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_strobe();
    test_commit_run();
    test_commit_idle();
    test_addr_err();
    test_drop_enfir();
    test_async_reset();
`ifdef FIR_CTRL_READBACK_EN
    test_readback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
